// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Types and constants shared by the I2C slave front end.
//                - tx_state_t : byte transmitter state encoding
//                - I2C_ACK / I2C_NACK : SDA levels in the acknowledge slot
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        ACK_WAIT = 2'd2,
        ACK_DONE = 2'd3
    } tx_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/byte_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : byte_transmitter
//  Description : Slave-side I2C byte transmitter for master-read transfers.
//                Takes a byte over a valid/ready handshake, drives it onto
//                SDA MSB-first (one bit per SCL low phase), releases SDA and
//                samples the master's ACK/NACK on the ninth SCL rise.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   system clock
//    reset        in   asynchronous, active-high reset
//    enable       in   master-read transaction in progress; low aborts
//    scl_rise     in   one-cycle pulse, synchronized SCL rising edge
//    scl_fall     in   one-cycle pulse, synchronized SCL falling edge
//    sda_in       in   synchronized SDA level (ACK sampling)
//    tx_valid     in   upstream byte available
//    tx_data      in   byte to send, captured on the handshake
//    tx_ready     out  block can accept a byte
//    sda_oe       out  1 = pull SDA low, 0 = release
//    scl_stretch  out  request to hold SCL low (data underrun)
//    ack_valid    out  one-cycle pulse when ACK/NACK is sampled
//    nack         out  last sampled acknowledge (1 = NACK), held
// ============================================================================
module byte_transmitter
    import i2c_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             scl_rise,
    input  logic             scl_fall,
    input  logic             sda_in,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             sda_oe,
    output logic             scl_stretch,
    output logic             ack_valid,
    output logic             nack
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             tx_ready_q;
    logic             sda_oe_q;
    logic             ack_valid_q;
    logic             nack_q;

    // Coincident rise and fall pulses are illegal; both are dropped so the
    // byte position cannot be corrupted by a glitching front end.
    logic w_rise;
    logic w_fall;
    assign w_rise = scl_rise & ~scl_fall;
    assign w_fall = scl_fall & ~scl_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_ready_q  <= 1'b1;
            sda_oe_q    <= 1'b0;
            ack_valid_q <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            ack_valid_q <= 1'b0;
            if (!enable) begin
                // Abort: release SDA and forget the partial byte; nack keeps
                // the last sampled acknowledge.
                state_q    <= IDLE;
                sda_oe_q   <= 1'b0;
                bit_cnt_q  <= '0;
                tx_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tx_valid) begin
                            shift_q    <= tx_data;
                            bit_cnt_q  <= '0;
                            sda_oe_q   <= ~tx_data[WIDTH-1];
                            tx_ready_q <= 1'b0;
                            state_q    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // Data changes only on SCL fall so it is stable
                        // throughout the SCL high phase.
                        if (w_fall) begin
                            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                sda_oe_q  <= 1'b0;
                                state_q   <= ACK_WAIT;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                                // Next MSB is the bit below the current one.
                                sda_oe_q  <= ~shift_q[WIDTH-2];
                            end
                        end
                    end
                    ACK_WAIT: begin
                        if (w_rise) begin
                            nack_q      <= (sda_in == I2C_NACK);
                            ack_valid_q <= 1'b1;
                            state_q     <= ACK_DONE;
                        end
                    end
                    ACK_DONE: begin
                        if (w_fall) begin
                            tx_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign sda_oe      = sda_oe_q;
    assign ack_valid   = ack_valid_q;
    assign nack        = nack_q;
    // Hold SCL low while the master is waiting on a byte we do not have yet.
    assign scl_stretch = (state_q == IDLE) & enable & ~tx_valid;

`ifndef SYNTHESIS
    a_no_dual_edge : assert property (@(posedge clk) disable iff (reset)
        !(scl_rise && scl_fall));
`endif

endmodule : byte_transmitter
`default_nettype wire

// File: tb/tb_byte_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_transmitter
//  Description : Self-checking bench for byte_transmitter. Expected SDA
//                drive levels are derived from the byte value (bit i of the
//                byte, MSB first, pull low for a 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_byte_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_in;
    logic       tx_valid;
    logic [7:0] tx_data;
    wire        tx_ready;
    wire        sda_oe;
    wire        scl_stretch;
    wire        ack_valid;
    wire        nack;

    int n_tests = 0;
    int n_fail  = 0;

    byte_transmitter #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .sda_in      (sda_in),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .sda_oe      (sda_oe),
        .scl_stretch (scl_stretch),
        .ack_valid   (ack_valid),
        .nack        (nack)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic pulse_rise();
        scl_rise = 1'b1;
        cyc();
        scl_rise = 1'b0;
    endtask

    task automatic pulse_fall();
        scl_fall = 1'b1;
        cyc();
        scl_fall = 1'b0;
    endtask

    // Drives one complete master-read byte and records what the DUT did.
    // oe_lo/oe_hi: sda_oe observed in the SCL low / high phase of each bit.
    task automatic run_byte(input logic [7:0] b, input logic ackbit,
                            output logic [7:0] oe_lo, output logic [7:0] oe_hi,
                            output logic oe_rel, output int pulses,
                            output logic nack_s, output logic rdy_s);
        enable   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = b;
        cyc();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            oe_lo[7-i] = sda_oe;
            idle($urandom_range(0, 2));
            pulse_rise();
            idle($urandom_range(0, 2));
            oe_hi[7-i] = sda_oe;
            pulse_fall();
        end
        oe_rel = sda_oe;
        idle($urandom_range(0, 2));
        sda_in = ackbit;
        pulses = 0;
        pulse_rise();
        pulses += int'(ack_valid);
        cyc();
        pulses += int'(ack_valid);
        cyc();
        pulses += int'(ack_valid);
        nack_s = nack;
        sda_in = 1'b1;
        pulse_fall();
        rdy_s = tx_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; scl_rise = 1'b0; scl_fall = 1'b0;
        sda_in = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        idle(3);
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_tests++; if (scl_stretch !== 1'b0) begin n_fail++; $display("FAIL reset_stretch: got %b want 0", scl_stretch); end
        n_tests++; if (ack_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ack_valid: got %b want 0", ack_valid); end
        n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b want 0", nack); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_a5_ack();
        logic [7:0] lo, hi;
        logic rel, nk, rdy;
        int pl;
        run_byte(8'hA5, 1'b0, lo, hi, rel, pl, nk, rdy);
        n_tests++; if (lo !== 8'b0101_1010) begin n_fail++; $display("FAIL a5_oe_low: got %b want 01011010", lo); end
        n_tests++; if (hi !== 8'b0101_1010) begin n_fail++; $display("FAIL a5_oe_high: got %b want 01011010", hi); end
        n_tests++; if (rel !== 1'b0) begin n_fail++; $display("FAIL a5_release: got %b want 0", rel); end
        n_tests++; if (pl !== 1) begin n_fail++; $display("FAIL a5_ack_pulses: got %0d want 1", pl); end
        n_tests++; if (nk !== 1'b0) begin n_fail++; $display("FAIL a5_nack: got %b want 0", nk); end
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL a5_ready_after: got %b want 1", rdy); end
    endtask

    task automatic test_nack_hold();
        logic [7:0] lo, hi, b;
        logic rel, nk, rdy;
        int pl;
        b = 8'($urandom);
        run_byte(b, 1'b1, lo, hi, rel, pl, nk, rdy);
        n_tests++; if (nk !== 1'b1) begin n_fail++; $display("FAIL nack_sample: got %b want 1", nk); end
        n_tests++; if (pl !== 1) begin n_fail++; $display("FAIL nack_pulses: got %0d want 1", pl); end
        enable = 1'b0;
        idle(4);
        n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_held_idle: got %b want 1", nack); end
        run_byte(8'h5A, 1'b0, lo, hi, rel, pl, nk, rdy);
        n_tests++; if (nk !== 1'b0) begin n_fail++; $display("FAIL nack_cleared: got %b want 0", nk); end
    endtask

    task automatic test_stretch();
        enable   = 1'b1;
        tx_valid = 1'b0;
        #1;
        n_tests++; if (scl_stretch !== 1'b1) begin n_fail++; $display("FAIL stretch_underrun: got %b want 1", scl_stretch); end
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        #1;
        n_tests++; if (scl_stretch !== 1'b0) begin n_fail++; $display("FAIL stretch_valid: got %b want 0", scl_stretch); end
        cyc();
        tx_valid = 1'b0;
        #1;
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL stretch_ready_drop: got %b want 0", tx_ready); end
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL stretch_first_bit: got %b want 1", sda_oe); end
        n_tests++; if (scl_stretch !== 1'b0) begin n_fail++; $display("FAIL stretch_in_shift: got %b want 0", scl_stretch); end
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_abort();
        logic [7:0] lo, hi;
        logic rel, nk, rdy, nack_before;
        int pl;
        nack_before = nack;
        enable   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        cyc();
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_rise();
            pulse_fall();
        end
        enable = 1'b0;
        cyc();
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", tx_ready); end
        n_tests++; if (nack !== nack_before) begin n_fail++; $display("FAIL abort_nack_kept: got %b want %b", nack, nack_before); end
        run_byte(8'h00, 1'b0, lo, hi, rel, pl, nk, rdy);
        n_tests++; if (lo !== 8'hFF) begin n_fail++; $display("FAIL abort_fresh_bits: got %b want 11111111", lo); end
        n_tests++; if (pl !== 1) begin n_fail++; $display("FAIL abort_fresh_ack: got %0d want 1", pl); end
    endtask

    task automatic test_ignored_idle_edges();
        logic [7:0] lo, hi, b;
        logic rel, nk, rdy;
        int pl;
        enable   = 1'b1;
        tx_valid = 1'b0;
        pulse_fall();
        pulse_rise();
        pulse_fall();
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_edges_ready: got %b want 1", tx_ready); end
        b = 8'($urandom);
        run_byte(b, 1'b0, lo, hi, rel, pl, nk, rdy);
        n_tests++; if (lo !== ~b) begin n_fail++; $display("FAIL idle_edges_bits: got %b want %b", lo, ~b); end
    endtask

    task automatic test_random();
        logic [7:0] lo, hi, b;
        logic rel, nk, rdy, a;
        int pl;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            a = 1'($urandom);
            run_byte(b, a, lo, hi, rel, pl, nk, rdy);
            n_tests++; if (lo !== ~b) begin n_fail++; $display("FAIL rand_oe_low byte=%h: got %b want %b", b, lo, ~b); end
            n_tests++; if (hi !== ~b) begin n_fail++; $display("FAIL rand_oe_high byte=%h: got %b want %b", b, hi, ~b); end
            n_tests++; if (rel !== 1'b0) begin n_fail++; $display("FAIL rand_release byte=%h: got %b want 0", b, rel); end
            n_tests++; if (pl !== 1) begin n_fail++; $display("FAIL rand_ack_pulses byte=%h: got %0d want 1", b, pl); end
            n_tests++; if (nk !== a) begin n_fail++; $display("FAIL rand_nack byte=%h: got %b want %b", b, nk, a); end
            n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rand_ready byte=%h: got %b want 1", b, rdy); end
        end
    endtask

    task automatic test_async_reset();
        enable   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        cyc();
        tx_valid = 1'b0;
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL areset_pre_oe: got %b want 1", sda_oe); end
        #3;
        reset = 1'b1;
        #1;
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL areset_sda_oe: got %b want 0", sda_oe); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", tx_ready); end
        n_tests++; if (ack_valid !== 1'b0) begin n_fail++; $display("FAIL areset_ack_valid: got %b want 0", ack_valid); end
        enable = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_a5_ack();
        test_nack_hold();
        test_stretch();
        test_abort();
        test_ignored_idle_edges();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_byte_transmitter
`default_nettype wire
